// File: rtl/mem_slot_arbiter.sv
// Four-slot time-division arbiter for the shared SDRAM port.
// Slot 0 video, slot 1 IO (download / floppy), slot 2 CPU, slot 3 CPU in turbo mode.
module mem_slot_arbiter #(
  parameter int PHASE_LEN = 4,
  parameter int AW        = 25
) (
  input  logic          clk32,
  input  logic          reset,
  input  logic          turbo,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_ds,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_din,
  input  logic          dio_req,
  input  logic [AW-1:0] dio_addr,
  input  logic [15:0]   dio_din,
  input  logic [1:0]    dsk_req,
  input  logic [AW-1:0] dsk_addr0,
  input  logic [AW-1:0] dsk_addr1,
  input  logic [15:0]   sdram_dout,
  output logic [AW-1:0] sdram_addr,
  output logic [15:0]   sdram_din,
  output logic [1:0]    sdram_ds,
  output logic          sdram_we,
  output logic          sdram_oe,
  output logic [1:0]    slot,
  output logic [2:0]    owner,
  output logic [5:0]    done,
  output logic [15:0]   rdata
);

  localparam int SW = $clog2(PHASE_LEN);

  typedef enum logic [2:0] {
    OWN_NONE    = 3'd0,
    OWN_VID     = 3'd1,
    OWN_CPU     = 3'd2,
    OWN_DIO     = 3'd3,
    OWN_DSK_INT = 3'd4,
    OWN_DSK_EXT = 3'd5
  } owner_t;

  logic [SW-1:0] sub;
  logic          wrap;
  logic [1:0]    next_slot;
  owner_t        owner_q;
  owner_t        sel;
  logic          last_dsk;  // 1: external floppy was served last
  logic [AW-1:0] sel_addr;
  logic [15:0]   sel_din;
  logic [1:0]    sel_ds;
  logic          sel_we;
  logic          sel_oe;
  logic [5:0]    done_set;

  assign wrap      = (sub == SW'(PHASE_LEN - 1));
  assign next_slot = slot + 2'd1;
  assign owner     = owner_q;
  assign done_set  = (owner_q == OWN_NONE) ? 6'd0 : (6'd1 << (3'(owner_q) - 3'd1));

  // Owner for the slot that starts at the next wrap edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel = OWN_NONE;
    unique case (next_slot)
      2'd0: if (vid_req) sel = OWN_VID;
      2'd1: begin
        if (dio_req)              sel = OWN_DIO;
        else if (dsk_req == 2'b11) sel = last_dsk ? OWN_DSK_INT : OWN_DSK_EXT;
        else if (dsk_req[0])      sel = OWN_DSK_INT;
        else if (dsk_req[1])      sel = OWN_DSK_EXT;
      end
      2'd2: if (cpu_req) sel = OWN_CPU;
      default: if (turbo && cpu_req) sel = OWN_CPU;
    endcase
  end

  // An idle slot keeps address and data so the bus does not toggle needlessly.
  always_comb begin
    sel_addr = sdram_addr;
    sel_din  = sdram_din;
    sel_ds   = 2'b00;
    sel_we   = 1'b0;
    sel_oe   = 1'b0;
    case (sel)
      OWN_VID: begin
        sel_addr = vid_addr;
        sel_oe   = 1'b1;
        sel_ds   = 2'b11;
      end
      OWN_CPU: begin
        sel_addr = cpu_addr;
        sel_din  = cpu_din;
        sel_we   = cpu_we;
        sel_oe   = ~cpu_we;
        sel_ds   = cpu_ds;
      end
      OWN_DIO: begin
        sel_addr = dio_addr;
        sel_din  = dio_din;
        sel_we   = 1'b1;
        sel_ds   = 2'b11;
      end
      OWN_DSK_INT: begin
        sel_addr = dsk_addr0;
        sel_oe   = 1'b1;
        sel_ds   = 2'b11;
      end
      OWN_DSK_EXT: begin
        sel_addr = dsk_addr1;
        sel_oe   = 1'b1;
        sel_ds   = 2'b11;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      sub        <= '0;
      slot       <= 2'd0;
      owner_q    <= OWN_NONE;
      last_dsk   <= 1'b1;
      done       <= 6'd0;
      rdata      <= 16'd0;
      sdram_addr <= '0;
      sdram_din  <= 16'd0;
      sdram_ds   <= 2'b00;
      sdram_we   <= 1'b0;
      sdram_oe   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      sub  <= wrap ? '0 : sub + SW'(1);
      done <= 6'd0;
      if (wrap) begin
        // Completion of the ending slot and grant of the next one share this edge.
        slot <= next_slot;
        done <= done_set;
        if (sdram_oe) rdata <= sdram_dout;
        owner_q    <= sel;
        sdram_addr <= sel_addr;
        sdram_din  <= sel_din;
        sdram_ds   <= sel_ds;
        sdram_we   <= sel_we;
        sdram_oe   <= sel_oe;
        if (sel == OWN_DSK_INT || sel == OWN_DSK_EXT)
          last_dsk <= (sel == OWN_DSK_EXT);
      end
    end
  end

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Directed bench for mem_slot_arbiter with PHASE_LEN=4: cycle k after reset release
// is slot (k/4)%4, sub k%4; outputs are sampled on the falling edge.
module tb_mem_slot_arbiter;

  localparam int AW = 25;

  logic          clk32 = 1'b0;
  logic          reset;
  logic          turbo;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          cpu_req;
  logic          cpu_we;
  logic [1:0]    cpu_ds;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_din;
  logic          dio_req;
  logic [AW-1:0] dio_addr;
  logic [15:0]   dio_din;
  logic [1:0]    dsk_req;
  logic [AW-1:0] dsk_addr0;
  logic [AW-1:0] dsk_addr1;
  logic [15:0]   sdram_dout;
  logic [AW-1:0] sdram_addr;
  logic [15:0]   sdram_din;
  logic [1:0]    sdram_ds;
  logic          sdram_we;
  logic          sdram_oe;
  logic [1:0]    slot;
  logic [2:0]    owner;
  logic [5:0]    done;
  logic [15:0]   rdata;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  mem_slot_arbiter #(.PHASE_LEN(4), .AW(AW)) dut (
    .clk32      (clk32),
    .reset      (reset),
    .turbo      (turbo),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_ds     (cpu_ds),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .dio_req    (dio_req),
    .dio_addr   (dio_addr),
    .dio_din    (dio_din),
    .dsk_req    (dsk_req),
    .dsk_addr0  (dsk_addr0),
    .dsk_addr1  (dsk_addr1),
    .sdram_dout (sdram_dout),
    .sdram_addr (sdram_addr),
    .sdram_din  (sdram_din),
    .sdram_ds   (sdram_ds),
    .sdram_we   (sdram_we),
    .sdram_oe   (sdram_oe),
    .slot       (slot),
    .owner      (owner),
    .done       (done),
    .rdata      (rdata)
  );

  always #5 clk32 = ~clk32;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk32);
    cyc++;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic check_bus(input string tag, input logic [2:0] own, input logic we,
                           input logic oe, input logic [1:0] ds, input logic [31:0] addr);
    check({tag, ".owner"}, 32'(owner), 32'(own));
    check({tag, ".we"}, 32'(sdram_we), 32'(we));
    check({tag, ".oe"}, 32'(sdram_oe), 32'(oe));
    check({tag, ".ds"}, 32'(sdram_ds), 32'(ds));
    check({tag, ".addr"}, 32'(sdram_addr), addr);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; turbo = 1'b0;
    vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_ds = 2'b00; cpu_addr = '0; cpu_din = 16'h0;
    dio_req = 1'b0; dio_addr = '0; dio_din = 16'h0;
    dsk_req = 2'b00; dsk_addr0 = '0; dsk_addr1 = '0;
    sdram_dout = 16'h0;
    repeat (3) @(negedge clk32);
    check_bus("reset", 3'd0, 1'b0, 1'b0, 2'b00, 32'h0);
    check("reset.slot", 32'(slot), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.rdata", 32'(rdata), 32'd0);
    reset = 1'b0;
    cyc   = 0;

    // Idle bus: slot advances every 4 cycles, nothing driven.
    for (int k = 0; k < 16; k++) begin
      go_to(k);
      check("idle.slot", 32'(slot), 32'((k / 4) % 4));
      check_bus("idle", 3'd0, 1'b0, 1'b0, 2'b00, 32'h0);
      check("idle.done", 32'(done), 32'd0);
    end

    // Video read in the slot 0 starting at cycle 16.
    vid_req = 1'b1; vid_addr = 25'h000123; sdram_dout = 16'hBEEF;
    go_to(16);
    check_bus("vid", 3'd1, 1'b0, 1'b1, 2'b11, 32'h123);
    go_to(17);
    vid_req = 1'b0;
    go_to(19);
    check_bus("vid.sub3", 3'd1, 1'b0, 1'b1, 2'b11, 32'h123);
    check("vid.done_early", 32'(done), 32'd0);
    go_to(20);
    check("vid.done", 32'(done), 32'b000001);
    check("vid.rdata", 32'(rdata), 32'hBEEF);
    check("vid.owner_clr", 32'(owner), 32'd0);
    check("vid.oe_clr", 32'(sdram_oe), 32'd0);
    go_to(21);
    check("vid.done_one", 32'(done), 32'd0);

    // dio beats both floppies; then floppies alternate starting with int.
    sdram_dout = 16'h0000;
    dio_req = 1'b1; dio_addr = 25'h000456; dio_din = 16'hA5A5;
    dsk_req = 2'b11; dsk_addr0 = 25'h0000D0; dsk_addr1 = 25'h0000E0;
    for (int b = 0; b < 3; b++) begin
      go_to(36 + 16 * b);
      check_bus("dio", 3'd3, 1'b1, 1'b0, 2'b11, 32'h456);
      check("dio.din", 32'(sdram_din), 32'hA5A5);
      go_to(40 + 16 * b);
      check("dio.done", 32'(done), 32'b000100);
      check("dio.rdata", 32'(rdata), 32'hBEEF);
    end
    go_to(69);
    dio_req = 1'b0;
    go_to(84);
    sdram_dout = 16'h1111;
    check_bus("dsk1", 3'd4, 1'b0, 1'b1, 2'b11, 32'hD0);
    go_to(88);
    check("dsk1.done", 32'(done), 32'b001000);
    check("dsk1.rdata", 32'(rdata), 32'h1111);
    go_to(100);
    sdram_dout = 16'h2222;
    check_bus("dsk2", 3'd5, 1'b0, 1'b1, 2'b11, 32'hE0);
    go_to(104);
    check("dsk2.done", 32'(done), 32'b010000);
    check("dsk2.rdata", 32'(rdata), 32'h2222);
    go_to(116);
    sdram_dout = 16'h3333;
    check_bus("dsk3", 3'd4, 1'b0, 1'b1, 2'b11, 32'hD0);

    // CPU write, turbo off: slot 2 only.
    go_to(117);
    dsk_req = 2'b00;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_ds = 2'b01; cpu_addr = 25'h000789; cpu_din = 16'h1234;
    go_to(120);
    check("dsk3.done", 32'(done), 32'b001000);
    check("dsk3.rdata", 32'(rdata), 32'h3333);
    check_bus("cpuw", 3'd2, 1'b1, 1'b0, 2'b01, 32'h789);
    check("cpuw.din", 32'(sdram_din), 32'h1234);
    go_to(124);
    check("cpuw.done", 32'(done), 32'b000010);
    check("cpuw.rdata", 32'(rdata), 32'h3333);
    check_bus("cpuw.slot3_idle", 3'd0, 1'b0, 1'b0, 2'b00, 32'h789);
    go_to(125);
    turbo = 1'b1;
    go_to(126);
    check("turbo_mid.owner", 32'(owner), 32'd0);
    go_to(128);
    check("turbo_mid.done", 32'(done), 32'd0);

    // Turbo on: slots 2 and 3 both write.
    go_to(136);
    check_bus("turbo.s2", 3'd2, 1'b1, 1'b0, 2'b01, 32'h789);
    go_to(140);
    check("turbo.done_s2", 32'(done), 32'b000010);
    check_bus("turbo.s3", 3'd2, 1'b1, 1'b0, 2'b01, 32'h789);
    go_to(141);
    check("turbo.done_gap", 32'(done), 32'd0);
    go_to(144);
    check("turbo.done_s3", 32'(done), 32'b000010);
    check("turbo.rdata", 32'(rdata), 32'h3333);

    // CPU read with request dropped at sub 1: still completes.
    go_to(145);
    turbo = 1'b0;
    cpu_we = 1'b0; cpu_ds = 2'b11; cpu_addr = 25'h000ABC; sdram_dout = 16'hCAFE;
    go_to(152);
    check_bus("cpur", 3'd2, 1'b0, 1'b1, 2'b11, 32'hABC);
    go_to(153);
    cpu_req = 1'b0;
    go_to(155);
    check_bus("cpur.sub3", 3'd2, 1'b0, 1'b1, 2'b11, 32'hABC);
    go_to(156);
    check("cpur.done", 32'(done), 32'b000010);
    check("cpur.rdata", 32'(rdata), 32'hCAFE);
    check("cpur.owner_clr", 32'(owner), 32'd0);
    check("cpur.oe_clr", 32'(sdram_oe), 32'd0);
    go_to(157);
    check("cpur.done_one", 32'(done), 32'd0);

    // Reset at sub 2 of a CPU read.
    cpu_req = 1'b1; cpu_addr = 25'h000321; sdram_dout = 16'h5A5A;
    go_to(169);
    check_bus("pre_rst", 3'd2, 1'b0, 1'b1, 2'b11, 32'h321);
    go_to(170);
    reset = 1'b1;
    #1;
    check_bus("rst_mid", 3'd0, 1'b0, 1'b0, 2'b00, 32'h0);
    check("rst_mid.slot", 32'(slot), 32'd0);
    check("rst_mid.done", 32'(done), 32'd0);
    check("rst_mid.rdata", 32'(rdata), 32'd0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk32);
    reset = 1'b0;
    cyc   = 0;
    for (int k = 0; k < 8; k++) begin
      go_to(k);
      check("post_rst.slot", 32'(slot), 32'((k / 4) % 4));
      check("post_rst.done", 32'(done), 32'd0);
      check("post_rst.owner", 32'(owner), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
